// File: rtl/bullet_bill_scheduler.sv
// rtl/bullet_bill_scheduler.sv - BulletBill slot allocator, mover and collision prober
//
// Owns three bullet slots. Fire requests allocate the lowest free slot; every
// STEP_FRAMES frames all live bullets advance one column, then each slot is
// probed against the enemy grid and matching enemies are killed.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   frame_tick                       one-cycle pulse per video frame
//   fire, fire_color, blockieee      fire request, bullet colour, spawn row
//   probe_row, probe_col             grid cell under the slot being probed
//   probe_color                      combinational grid lookup of that cell
//   kill_valid, kill_row, kill_col   registered kill command to the grid owner
//   fire_drop                        registered pulse, fire request rejected
//   bulletBillColor/XLoc/YLoc        slot state for the graphics generator

module bullet_bill_scheduler #(
  parameter int STEP_FRAMES = 4,
  parameter int SPAWN_COL   = 2,
  parameter int LAST_COL    = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        fire,
  input  logic [11:0] fire_color,
  input  logic [3:0]  blockieee,
  output logic [2:0]  probe_row,
  output logic [2:0]  probe_col,
  input  logic [11:0] probe_color,
  output logic        kill_valid,
  output logic [2:0]  kill_row,
  output logic [2:0]  kill_col,
  output logic        fire_drop,
  output logic [11:0] bulletBillColor [3],
  output logic [3:0]  bulletBillXLoc  [3],
  output logic [3:0]  bulletBillYLoc  [3]
);

  localparam int            CW        = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;
  localparam logic [CW-1:0] STEP_LAST = CW'(STEP_FRAMES - 1);
  localparam logic [3:0]    SPAWN_X   = 4'(SPAWN_COL);
  localparam logic [3:0]    LAST_X    = 4'(LAST_COL);

  typedef enum logic [2:0] {IDLE, MOVE, PROBE0, PROBE1, PROBE2} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] step_cnt_q, step_cnt_d;
  logic          move_pending_q, move_pending_d;
  logic          fire_pending_q, fire_pending_d;
  logic [11:0]   lat_color_q, lat_color_d;
  logic [3:0]    lat_row_q, lat_row_d;

  logic [11:0]   color_q [3];
  logic [11:0]   color_d [3];
  logic [3:0]    x_q [3];
  logic [3:0]    x_d [3];
  logic [3:0]    y_q [3];
  logic [3:0]    y_d [3];

  logic          kill_valid_q, kill_valid_d;
  logic [2:0]    kill_row_q, kill_row_d;
  logic [2:0]    kill_col_q, kill_col_d;
  logic          fire_drop_q, fire_drop_d;

  // Cells killed by slots 0 and 1 earlier in the current sweep. The grid owner
  // clears a cell one cycle after kill_valid, so a later slot in the same
  // sweep may still see the stale enemy and must ignore it.
  logic          swept_v_q [2];
  logic          swept_v_d [2];
  logic [2:0]    swept_row_q [2];
  logic [2:0]    swept_row_d [2];
  logic [2:0]    swept_col_q [2];
  logic [2:0]    swept_col_d [2];

  // Probe datapath for the slot selected by the current probe state
  logic          probe_active;
  logic [1:0]    probe_idx;
  logic [11:0]   cur_color;
  logic [3:0]    cur_x;
  logic [3:0]    cur_y;
  logic [2:0]    cell_row;
  logic [2:0]    cell_col;
  logic          probeable;
  logic          swept_hit;
  logic [11:0]   eff_color;

  always_comb begin
    probe_active = 1'b1;
    probe_idx    = 2'd0;
    case (state_q)
      PROBE0:  probe_idx = 2'd0;
      PROBE1:  probe_idx = 2'd1;
      PROBE2:  probe_idx = 2'd2;
      default: probe_active = 1'b0;
    endcase

    cur_color = color_q[probe_idx];
    cur_x     = x_q[probe_idx];
    cur_y     = y_q[probe_idx];
    cell_row  = cur_y[3:1];
    cell_col  = cur_x[3:1] - 3'd2;

    // Bullets sit between enemy rows/columns except on odd rows and even
    // columns inside the grid window.
    probeable = probe_active && (cur_color != 12'h000) &&
                cur_y[0] && (cur_y <= 4'd9) &&
                !cur_x[0] && (cur_x >= 4'd4) && (cur_x <= 4'd14);

    swept_hit = (swept_v_q[0] && swept_row_q[0] == cell_row && swept_col_q[0] == cell_col) ||
                (swept_v_q[1] && swept_row_q[1] == cell_row && swept_col_q[1] == cell_col);
    eff_color = swept_hit ? 12'h000 : probe_color;

    probe_row = probeable ? cell_row : 3'd0;
    probe_col = probeable ? cell_col : 3'd0;
  end

  // Lowest-index empty slot
  logic       free_found;
  logic [1:0] free_idx;

  always_comb begin
    free_found = 1'b0;
    free_idx   = 2'd0;
    for (int i = 2; i >= 0; i--) begin
      if (color_q[i] == 12'h000) begin
        free_found = 1'b1;
        free_idx   = 2'(i);
      end
    end
  end

  logic tick_wrap;

  always_comb begin
    state_d        = state_q;
    step_cnt_d     = step_cnt_q;
    move_pending_d = move_pending_q;
    fire_pending_d = fire_pending_q;
    lat_color_d    = lat_color_q;
    lat_row_d      = lat_row_q;
    color_d        = color_q;
    x_d            = x_q;
    y_d            = y_q;
    swept_v_d      = swept_v_q;
    swept_row_d    = swept_row_q;
    swept_col_d    = swept_col_q;
    kill_valid_d   = 1'b0;
    kill_row_d     = 3'd0;
    kill_col_d     = 3'd0;
    fire_drop_d    = 1'b0;
    tick_wrap      = 1'b0;

    if (frame_tick) begin
      if (step_cnt_q == STEP_LAST) begin
        step_cnt_d = '0;
        tick_wrap  = 1'b1;
      end else begin
        step_cnt_d = step_cnt_q + 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (move_pending_q) begin
          move_pending_d = 1'b0;
          state_d        = MOVE;
        end else if (fire_pending_q) begin
          fire_pending_d = 1'b0;
          if (free_found && lat_color_q != 12'h000 && lat_row_q <= 4'd10) begin
            color_d[free_idx] = lat_color_q;
            x_d[free_idx]     = SPAWN_X;
            y_d[free_idx]     = lat_row_q;
          end else begin
            fire_drop_d = 1'b1;
          end
        end
      end

      MOVE: begin
        for (int i = 0; i < 3; i++) begin
          if (color_q[i] != 12'h000) begin
            if (x_q[i] == LAST_X) begin
              color_d[i] = 12'h000;
              x_d[i]     = 4'd0;
              y_d[i]     = 4'd0;
            end else begin
              x_d[i] = x_q[i] + 4'd1;
            end
          end
        end
        swept_v_d[0] = 1'b0;
        swept_v_d[1] = 1'b0;
        state_d      = PROBE0;
      end

      PROBE0, PROBE1, PROBE2: begin
        // Any enemy hit retires the bullet; only a colour match kills it.
        if (probeable && eff_color != 12'h000) begin
          color_d[probe_idx] = 12'h000;
          x_d[probe_idx]     = 4'd0;
          y_d[probe_idx]     = 4'd0;
          if (eff_color == cur_color) begin
            kill_valid_d = 1'b1;
            kill_row_d   = cell_row;
            kill_col_d   = cell_col;
            if (probe_idx != 2'd2) begin
              swept_v_d[probe_idx[0]]   = 1'b1;
              swept_row_d[probe_idx[0]] = cell_row;
              swept_col_d[probe_idx[0]] = cell_col;
            end
          end
        end
        case (state_q)
          PROBE0:  state_d = PROBE1;
          PROBE1:  state_d = PROBE2;
          default: state_d = IDLE;
        endcase
      end

      default: state_d = IDLE;
    endcase

    // New events win over the IDLE consumption of the same flag.
    if (tick_wrap) begin
      move_pending_d = 1'b1;
    end
    if (fire) begin
      fire_pending_d = 1'b1;
      lat_color_d    = fire_color;
      lat_row_d      = blockieee;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      step_cnt_q     <= '0;
      move_pending_q <= 1'b0;
      fire_pending_q <= 1'b0;
      lat_color_q    <= 12'h000;
      lat_row_q      <= 4'd0;
      kill_valid_q   <= 1'b0;
      kill_row_q     <= 3'd0;
      kill_col_q     <= 3'd0;
      fire_drop_q    <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        color_q[i] <= 12'h000;
        x_q[i]     <= 4'd0;
        y_q[i]     <= 4'd0;
      end
      for (int i = 0; i < 2; i++) begin
        swept_v_q[i]   <= 1'b0;
        swept_row_q[i] <= 3'd0;
        swept_col_q[i] <= 3'd0;
      end
    end else begin
      state_q        <= state_d;
      step_cnt_q     <= step_cnt_d;
      move_pending_q <= move_pending_d;
      fire_pending_q <= fire_pending_d;
      lat_color_q    <= lat_color_d;
      lat_row_q      <= lat_row_d;
      kill_valid_q   <= kill_valid_d;
      kill_row_q     <= kill_row_d;
      kill_col_q     <= kill_col_d;
      fire_drop_q    <= fire_drop_d;
      color_q        <= color_d;
      x_q            <= x_d;
      y_q            <= y_d;
      swept_v_q      <= swept_v_d;
      swept_row_q    <= swept_row_d;
      swept_col_q    <= swept_col_d;
    end
  end

  assign kill_valid      = kill_valid_q;
  assign kill_row        = kill_row_q;
  assign kill_col        = kill_col_q;
  assign fire_drop       = fire_drop_q;
  assign bulletBillColor = color_q;
  assign bulletBillXLoc  = x_q;
  assign bulletBillYLoc  = y_q;

endmodule

// File: tb/tb_bullet_bill_scheduler.sv
// tb/tb_bullet_bill_scheduler.sv - randomized and directed bench for bullet_bill_scheduler
`timescale 1ns/1ps

module tb_bullet_bill_scheduler;

  localparam int STEP = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_tick = 1'b0;
  logic        fire = 1'b0;
  logic [11:0] fire_color = 12'h000;
  logic [3:0]  blockieee = 4'd0;
  logic [2:0]  probe_row;
  logic [2:0]  probe_col;
  logic [11:0] probe_color;
  logic        kill_valid;
  logic [2:0]  kill_row;
  logic [2:0]  kill_col;
  logic        fire_drop;
  logic [11:0] bb_color [3];
  logic [3:0]  bb_x [3];
  logic [3:0]  bb_y [3];

  always #5 clk = ~clk;

  bullet_bill_scheduler #(.STEP_FRAMES(STEP), .SPAWN_COL(2), .LAST_COL(15)) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .fire(fire),
    .fire_color(fire_color), .blockieee(blockieee),
    .probe_row(probe_row), .probe_col(probe_col), .probe_color(probe_color),
    .kill_valid(kill_valid), .kill_row(kill_row), .kill_col(kill_col),
    .fire_drop(fire_drop), .bulletBillColor(bb_color),
    .bulletBillXLoc(bb_x), .bulletBillYLoc(bb_y)
  );

  // Enemy grid owner: combinational lookup, kill clears the cell on the next edge
  logic [11:0] grid [5][6];
  logic        cfg_we = 1'b0;
  logic        cfg_clr = 1'b0;
  logic [2:0]  cfg_r = 3'd0;
  logic [2:0]  cfg_c = 3'd0;
  logic [11:0] cfg_v = 12'h000;

  always_comb begin
    probe_color = 12'h000;
    if (probe_row < 3'd5 && probe_col < 3'd6) probe_color = grid[probe_row][probe_col];
  end

  always @(posedge clk) begin
    if (cfg_clr) begin
      for (int r = 0; r < 5; r++)
        for (int c = 0; c < 6; c++) grid[r][c] <= 12'h000;
    end else if (cfg_we) begin
      grid[cfg_r][cfg_c] <= cfg_v;
    end
    if (kill_valid && kill_row < 3'd5 && kill_col < 3'd6) grid[kill_row][kill_col] <= 12'h000;
  end

  // Output monitor
  logic [5:0] act_kill [0:1023];
  int act_kill_n = 0;
  int act_drops  = 0;
  int overlap_n  = 0;
  int probe20_n  = 0;

  always @(negedge clk) begin
    if (kill_valid) begin
      if (act_kill_n < 1024) act_kill[act_kill_n] = {kill_row, kill_col};
      act_kill_n++;
    end
    if (fire_drop) act_drops++;
    if (kill_valid && fire_drop) overlap_n++;
    if (probe_row == 3'd2 && probe_col == 3'd0) probe20_n++;
  end

  // Reference model: slot contents, step counter and enemy grid, updated
  // atomically per fire request or frame tick.
  logic [11:0] m_col [3];
  logic [3:0]  m_x [3];
  logic [3:0]  m_y [3];
  int          m_cnt;
  logic [11:0] mgrid [5][6];
  logic [5:0]  exp_kill [0:1023];
  int          exp_kill_n = 0;
  int          exp_drops = 0;
  int          kchk = 0;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_col[i] = 12'h000; m_x[i] = 4'd0; m_y[i] = 4'd0;
    end
    m_cnt = 0;
  endtask

  task automatic model_fire(input logic [11:0] c, input logic [3:0] r);
    int slot = -1;
    for (int i = 2; i >= 0; i--) if (m_col[i] == 12'h000) slot = i;
    if (slot < 0 || c == 12'h000 || r > 4'd10) begin
      exp_drops++;
    end else begin
      m_col[slot] = c; m_x[slot] = 4'd2; m_y[slot] = r;
    end
  endtask

  task automatic model_sweep();
    for (int i = 0; i < 3; i++) begin
      if (m_col[i] != 12'h000) begin
        if (m_x[i] == 4'd15) begin
          m_col[i] = 12'h000; m_x[i] = 4'd0; m_y[i] = 4'd0;
        end else begin
          m_x[i] = m_x[i] + 4'd1;
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      if (m_col[i] != 12'h000 && m_y[i] % 2 == 1 && m_y[i] <= 9 &&
          m_x[i] % 2 == 0 && m_x[i] >= 4 && m_x[i] <= 14) begin
        int r = int'(m_y[i]) / 2;
        int c = int'(m_x[i]) / 2 - 2;
        if (mgrid[r][c] != 12'h000) begin
          if (mgrid[r][c] == m_col[i]) begin
            exp_kill[exp_kill_n] = {3'(r), 3'(c)};
            exp_kill_n++;
            mgrid[r][c] = 12'h000;
          end
          m_col[i] = 12'h000; m_x[i] = 4'd0; m_y[i] = 4'd0;
        end
      end
    end
  endtask

  task automatic model_tick();
    m_cnt++;
    if (m_cnt == STEP) begin
      m_cnt = 0;
      model_sweep();
    end
  endtask

  // Stimulus tasks: all start and end on a falling edge
  task automatic do_reset();
    rst = 1'b1; frame_tick = 1'b0; fire = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic do_fire(input logic [11:0] c, input logic [3:0] r);
    fire = 1'b1; fire_color = c; blockieee = r;
    @(negedge clk);
    fire = 1'b0; fire_color = 12'(($urandom)); blockieee = 4'($urandom);
    repeat (8) @(negedge clk);
    model_fire(c, r);
  endtask

  task automatic do_tick();
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    repeat (8) @(negedge clk);
    model_tick();
  endtask

  task automatic do_step();
    repeat (STEP) do_tick();
  endtask

  task automatic grid_set(input int r, input int c, input logic [11:0] v);
    cfg_we = 1'b1; cfg_r = 3'(r); cfg_c = 3'(c); cfg_v = v;
    @(negedge clk);
    cfg_we = 1'b0;
    mgrid[r][c] = v;
  endtask

  task automatic grid_clear();
    cfg_clr = 1'b1;
    @(negedge clk);
    cfg_clr = 1'b0;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 6; c++) mgrid[r][c] = 12'h000;
  endtask

  function automatic logic [11:0] pick_color();
    case ($urandom_range(0, 7))
      0:       return 12'h000;
      1, 2:    return 12'h0F0;
      3, 4:    return 12'h00F;
      default: return 12'hF00;
    endcase
  endfunction

  task automatic check_all();
    for (int i = 0; i < 3; i++)
      chk($sformatf("slot%0d", i), {bb_color[i], bb_x[i], bb_y[i]}, {m_col[i], m_x[i], m_y[i]});
    chk("kill_count", act_kill_n, exp_kill_n);
    while (kchk < act_kill_n && kchk < exp_kill_n && kchk < 1024) begin
      chk("kill_cell", act_kill[kchk], exp_kill[kchk]);
      kchk++;
    end
    chk("drop_count", act_drops, exp_drops);
    chk("probe_idle", {probe_row, probe_col}, 6'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k0;
    int p0;
    int found;

    model_reset();
    @(negedge clk);
    grid_clear();
    do_reset();

    // Reset state
    chk("rst_outputs", {kill_valid, fire_drop, probe_row, probe_col}, 8'd0);
    for (int i = 0; i < 3; i++)
      chk("rst_slot", {bb_color[i], bb_x[i], bb_y[i]}, 20'd0);

    // First allocation
    do_fire(12'hF00, 4'd3);
    chk("first_fire_slot0", {bb_color[0], bb_x[0], bb_y[0]}, {12'hF00, 4'd2, 4'd3});
    check_all();

    // Fill all slots, fourth is dropped; colour 0 is dropped
    do_reset();
    do_fire(12'h111, 4'd1);
    do_fire(12'h222, 4'd2);
    do_fire(12'h333, 4'd4);
    do_fire(12'h444, 4'd5);
    chk("full_drop", act_drops, 1);
    check_all();
    do_reset();
    do_fire(12'h000, 4'd3);
    chk("zero_color_drop", act_drops, 2);
    do_fire(12'h123, 4'd11);
    check_all();

    // Stepping a single bullet to retirement
    do_reset();
    do_fire(12'h0F0, 4'd3);
    do_step();
    chk("first_step_x", bb_x[0], 4'd3);
    check_all();
    for (int s = 0; s < 12; s++) do_step();
    chk("at_last_col", {bb_color[0], bb_x[0]}, {12'h0F0, 4'd15});
    do_step();
    chk("retired", bb_color[0], 12'h000);
    check_all();

    // Matching enemy is killed; mismatched enemy absorbs the bullet
    do_reset();
    do_fire(12'h0F0, 4'd5);
    do_step();
    grid_set(2, 0, 12'h0F0);
    p0 = probe20_n;
    k0 = act_kill_n;
    do_step();
    chk("probe_2_0_seen", probe20_n - p0, 1);
    chk("match_kill", act_kill_n - k0, 1);
    chk("match_slot_clear", bb_color[0], 12'h000);
    check_all();
    do_reset();
    grid_clear();
    do_fire(12'h0F0, 4'd5);
    do_step();
    grid_set(2, 0, 12'h00F);
    k0 = act_kill_n;
    do_step();
    chk("absorb_no_kill", act_kill_n - k0, 0);
    chk("absorb_slot_clear", bb_color[0], 12'h000);
    check_all();

    // Two bullets on the same cell: one kill, second bullet carries on
    do_reset();
    grid_clear();
    do_fire(12'h0F0, 4'd5);
    do_fire(12'h0F0, 4'd5);
    do_step();
    grid_set(2, 0, 12'h0F0);
    k0 = act_kill_n;
    do_step();
    chk("dup_one_kill", act_kill_n - k0, 1);
    chk("dup_slot0", bb_color[0], 12'h000);
    chk("dup_slot1", {bb_color[1], bb_x[1]}, {12'h0F0, 4'd4});
    check_all();

    // Reset during PROBE1 with a matching enemy under slot 1
    do_reset();
    grid_clear();
    do_fire(12'h00F, 4'd2);
    do_fire(12'h0F0, 4'd5);
    do_step();
    check_all();
    grid_set(2, 0, 12'h0F0);
    repeat (STEP - 1) do_tick();
    k0 = act_kill_n;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    found = 0;
    for (int n = 0; n < 20 && found == 0; n++) begin
      @(negedge clk);
      if (probe_row == 3'd2 && probe_col == 3'd0) found = 1;
    end
    chk("probe1_reached", found, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("midsweep_outputs", {kill_valid, fire_drop, probe_row, probe_col}, 8'd0);
    for (int i = 0; i < 3; i++)
      chk("midsweep_slot", {bb_color[i], bb_x[i], bb_y[i]}, 20'd0);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("midsweep_no_kill", act_kill_n - k0, 0);
    model_reset();
    check_all();

    // Randomized traffic against the model
    do_reset();
    for (int ev = 0; ev < 240; ev++) begin
      if (ev % 60 == 0) begin
        grid_clear();
        for (int r = 0; r < 5; r++)
          for (int c = 0; c < 6; c++)
            if ($urandom_range(0, 2) != 0) grid_set(r, c, pick_color());
      end
      if ($urandom_range(0, 9) < 3) begin
        logic [3:0] row;
        row = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 12))
                                          : 4'(2 * $urandom_range(0, 4) + 1);
        do_fire(pick_color(), row);
      end else begin
        do_tick();
      end
      check_all();
    end

    chk("kill_drop_overlap", overlap_n, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bullet_bill_scheduler.md
Name: bullet_bill_scheduler

Overview:
- Owns the three BulletBill slots that feed the graphics generator's bulletBillColor/XLoc/YLoc arrays.
- Allocates a slot on each fire request and advances live bullets one cell right every STEP_FRAMES frames.
- After each advance, sequences a collision probe of every slot against the DDAVER grid and issues kill commands to the grid owner.

Parameters:
- STEP_FRAMES, 4, frames between bullet advances (≥1).
- SPAWN_COL, 2, column of a newly fired bullet.
- LAST_COL, 15, last visible column; a bullet advancing from it retires.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- frame_tick  in  1  one-cycle pulse per video frame
- fire  in  1  one-cycle fire request
- fire_color  in  12  RGB444 colour of the requested bullet
- blockieee  in  4  Blockieee row (0..10)
- probe_row  out  3  DDAVER row index under probe
- probe_col  out  3  DDAVER column index under probe
- probe_color  in  12  combinational grid lookup of (probe_row, probe_col); 0 = no enemy
- kill_valid  out  1  one-cycle pulse: clear DDAVER at kill_row/kill_col
- kill_row  out  3  row of kill
- kill_col  out  3  column of kill
- fire_drop  out  1  one-cycle pulse: fire rejected
- bulletBillColor  out  12 x3  slot colours; 0 = empty slot
- bulletBillXLoc  out  4 x3  slot columns
- bulletBillYLoc  out  4 x3  slot rows

Behaviour:
- Reset: all slot colours, X and Y are 0. kill_valid, fire_drop, probe_row and probe_col are 0. Step counter is 0. State is IDLE. Pending flags are clear.
- A slot is live when its colour is nonzero.
- Step counter: increments on every frame_tick in any state. On reaching STEP_FRAMES-1 with a tick, it wraps to 0 and sets move_pending.
- A fire pulse sets fire_pending and latches fire_color and blockieee. A fire arriving while fire_pending is already set overwrites the latched values; no drop is signalled for the overwritten request.
- FSM states: IDLE, MOVE, PROBE0, PROBE1, PROBE2.
- IDLE priority 1: if move_pending, clear it and go to MOVE.
- IDLE priority 2: else if fire_pending, clear it and allocate the lowest-index empty slot with colour=latched colour, X=SPAWN_COL, Y=latched row. Takes 1 cycle; stays in IDLE.
- Fire rejection: if no slot is free, the latched colour is 0, or the latched row is >10, pulse fire_drop for 1 cycle instead of allocating.
- MOVE, 1 cycle: every live slot with X==LAST_COL retires (colour, X and Y all set to 0). Every other live slot does X+1. Next state is PROBE0.
- PROBEi, 1 cycle each: slot i is probeable when all of the following hold:
  - slot is live;
  - Y is odd and Y ≤ 9;
  - X is even and 4 ≤ X ≤ 14.
- probe_row=Y>>1 and probe_col=(X>>1)-2, driven combinationally from slot i during PROBEi. Outside probe states, or when the slot is not probeable, probe outputs are 0 and probe_color is ignored.
- Probe result when probeable and probe_color≠0:
  - probe_color == slot colour: kill_valid pulses next cycle with the probed row/col, and slot i retires.
  - probe_color ≠ slot colour: slot i retires (absorbed), no kill.
  - probe_color==0: no action.
- Same-sweep duplicate: if a later slot probes a cell already killed earlier in the same sweep, it treats probe_color as 0. The grid update lags one cycle.
- PROBE2 returns to IDLE. A full sweep takes 4 cycles after leaving IDLE.
- kill_valid and fire_drop are registered, one-cycle pulses, never asserted together. Allocation and kill can never collide.
- rst mid-sweep: returns to reset values on the next edge. No kill is issued for an in-progress probe.

Test Plan:
- Reset, then fire with fire_color=12'hF00, blockieee=3 → after ≤2 cycles slot0 = {F00, X=2, Y=3}; slots 1-2 colour 0.
- Fire 4 times (colours 0x111, 0x222, 0x333, 0x444, spaced) with no frame ticks → slots 0-2 hold 111/222/333; 4th fire gives fire_drop=1 for 1 cycle. Separately, fire with colour 0 → fire_drop.
- One live bullet at X=2, STEP_FRAMES=4, send 4 frame_ticks → X=3 after 4th tick's sweep. Continue to X=15, then one more step → colour 0.
- Bullet 0x0F0 at X=3,Y=5, grid model returns 0x0F0 at (2,0), one step → X=4, probe_row=2, probe_col=0 in PROBE0, kill_valid with (2,0), slot cleared. Repeat with grid colour 0x00F → slot cleared, no kill.
- Two 0x0F0 bullets in the same cell, grid matching, one step → exactly one kill_valid pulse; first slot cleared; second slot continues at X+1.
- rst asserted during PROBE1 with a matching enemy → no kill_valid, all outputs 0 next cycle.
